count_controller: RTL

COUNT_CONTROLLER -- requirements
Module: count_controller

---
 rtl/count_controller_pkg.sv | 17 +
 rtl/count_controller_step_counter.sv | 28 ++
 rtl/ctrl_defs.vh | 13 +
 rtl/count_controller.sv | 123 ++++++++++++
 4 files changed

// File: rtl/count_controller_pkg.sv
// count_controller_pkg: state type and default width for count_controller.
// The encodings come from the shared ctrl_defs.vh, so every sequencer block
// decodes the same state values.
package count_controller_pkg;

`include "ctrl_defs.vh"

    typedef enum logic [1:0] {
        ST_IDLE  = `CTRL_ST_IDLE,
        ST_CLEAR = `CTRL_ST_CLEAR,
        ST_RUN   = `CTRL_ST_RUN,
        ST_DONE  = `CTRL_ST_DONE
    } ctrl_state_t;

    localparam int DEFAULT_LEN_W = `CTRL_LEN_W_DEFAULT;

endpackage

// File: rtl/count_controller_step_counter.sv
// step_counter: loadable down-counter holding the enable cycles left in a run.
// Load has priority over decrement. The counter never wraps below zero.
module step_counter #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         dec,
    output logic [W-1:0] value,
    output logic         zero
);

    assign zero = (value == '0);

    // Count register: reset clears, load replaces, dec steps down by one.
    always_ff @(posedge clk) begin
        if (rst) begin
            value <= '0;
        end else if (load) begin
            value <= load_value;
        end else if (dec && !zero) begin
            value <= value - W'(1);
        end
    end

endmodule

// File: rtl/ctrl_defs.vh
// Shared sequencer definitions: state encodings and default run-length width.
// Included by count_controller_pkg and by the other sequencer blocks.
`ifndef CTRL_DEFS_VH
`define CTRL_DEFS_VH

`define CTRL_ST_IDLE        2'b00
`define CTRL_ST_CLEAR       2'b01
`define CTRL_ST_RUN         2'b10
`define CTRL_ST_DONE        2'b11

`define CTRL_LEN_W_DEFAULT  4

`endif

// File: rtl/count_controller.sv
// count_controller: IDLE -> CLEAR -> RUN -> DONE sequencer that issues one
// clear strobe, then N count-enable cycles, then a single done pulse.
// A latched len of 0 means 2^LEN_W cycles; the internal count is one bit
// wider so that value fits, and remaining shows only the low LEN_W bits.
//
// Handshake: a run is accepted on a rising edge where ready=1 and start=1;
// len is sampled on that edge only. start while busy is dropped, not queued.
//
// Optional feature macro: CTRL_PAUSE_EN adds the pause input, which freezes
// cnt_en, the count and the state while in RUN.
module count_controller
    import count_controller_pkg::*;
#(
    parameter int LEN_W = DEFAULT_LEN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
`ifdef CTRL_PAUSE_EN
    input  logic             pause,
`endif
    output logic             ready,
    output logic             cnt_clr,
    output logic             cnt_en,
    output logic             busy,
    output logic             done,
    output logic [LEN_W-1:0] remaining
);

    localparam int CW = LEN_W + 1;

    ctrl_state_t   state;
    ctrl_state_t   state_next;

    logic [CW-1:0] count;
    logic          count_zero;
    logic [CW-1:0] load_value;
    logic          accept;
    logic          run_step;
    logic          last_step;
    logic          paused;

`ifdef CTRL_PAUSE_EN
    assign paused = pause;
`else
    assign paused = 1'b0;
`endif

    // A zero length request stands for the full 2^LEN_W cycles.
    assign load_value = (len == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, len};
    assign accept     = (state == ST_IDLE) && start;

    // One enable cycle is issued whenever RUN is not frozen; the count
    // guard keeps a corrupted zero count from underflowing.
    assign run_step   = (state == ST_RUN) && !paused && !count_zero;
    assign last_step  = run_step && (count == CW'(1));

    assign remaining  = count[LEN_W-1:0];

    step_counter #(
        .W (CW)
    ) u_step_counter (
        .clk        (clk),
        .rst        (rst),
        .load       (accept),
        .load_value (load_value),
        .dec        (run_step),
        .value      (count),
        .zero       (count_zero)
    );

    // State register; reset aborts any run without a done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and output decode from the registered state.
    always_comb begin
        state_next = state;
        ready      = 1'b0;
        busy       = 1'b1;
        cnt_clr    = 1'b0;
        cnt_en     = 1'b0;
        done       = 1'b0;
        unique case (state)
            ST_IDLE: begin
                ready = 1'b1;
                busy  = 1'b0;
                if (start) begin
                    state_next = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                cnt_clr    = 1'b1;
                state_next = ST_RUN;
            end
            ST_RUN: begin
                cnt_en = run_step;
                if (last_step) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // The three datapath strobes never overlap.
    a_strobes_exclusive: assert property (
        @(posedge clk) disable iff (rst) $onehot0({cnt_clr, cnt_en, done})
    );

endmodule
